aes_job_ctrl: RTL and testbench

Sequencer and arbiter in front of the combined AES encrypt/decrypt core. It accepts a 128-bit key, triggers key expansion and waits out the expansion latency. It then arbitrates encrypt/decrypt jobs from two requesters with round-robin priority and holds the core inputs stable for the datapath latency. It returns each result through a valid/ready response port tagged with the requester ID.

---
 rtl/aes_job_ctrl.sv | 172 +++++++++++++++++
 tb/tb_aes_job_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_ctrl.sv
// aes_job_ctrl
//   Sequencer and arbiter in front of a combined AES encrypt/decrypt core.
//   A 128-bit key is accepted and registered, and the core's key expansion
//   is strobed. The controller then waits KEY_LAT cycles before it serves
//   jobs. Jobs from two requesters are granted round-robin. The core inputs
//   are held for CORE_LAT cycles, and the result is returned on a
//   valid/ready port tagged with the requester id.
//
// Ports
//   HCLK, rst                     clock (rising edge), synchronous active-high reset
//   key_valid/key_ready/key_in    key offer handshake, 128-bit key
//   reqN_valid/reqN_ready         job offer handshake for requester N (0/1)
//   reqN_encrypt, reqN_data       job mode (1 = encrypt) and 128-bit block
//   rsp_valid/rsp_ready           result handshake
//   rsp_data, rsp_id              128-bit result and owning requester
//   key_loaded                    an expanded key is present
//   core_keyEna                   one-cycle key-expansion strobe to the core
//   core_keyword/encrypt/data     registered core inputs
//   core_result                   core output
module aes_job_ctrl #(
    parameter int KEY_LAT  = 10,
    parameter int CORE_LAT = 11
) (
    input  logic         HCLK,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic         req0_encrypt,
    input  logic         req1_encrypt,
    input  logic [127:0] req0_data,
    input  logic [127:0] req1_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_id,
    output logic         key_loaded,
    output logic         core_keyEna,
    output logic [127:0] core_keyword,
    output logic         core_encrypt,
    output logic [127:0] core_data,
    input  logic [127:0] core_result
);

    localparam int MAX_LAT = (KEY_LAT > CORE_LAT) ? KEY_LAT : CORE_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] KEY_CNT_INIT  = CNT_W'(KEY_LAT - 1);
    localparam logic [CNT_W-1:0] CORE_CNT_INIT = CNT_W'(CORE_LAT - 1);

    typedef enum logic [2:0] {
        NOKEY,
        KEYEXP,
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             rr_prio;   // 0: requester 0 wins a tie, 1: requester 1 wins
    logic             gnt_id;
    logic             key_hs;
    logic             gnt0;
    logic             gnt1;

    assign cnt_zero = (cnt == '0);

    always_comb begin
        state_nx   = state;
        key_ready  = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (!rst) begin
            unique case (state)
                NOKEY: begin
                    key_ready = 1'b1;
                    if (key_valid) state_nx = KEYEXP;
                end
                KEYEXP: begin
                    if (cnt_zero) state_nx = IDLE;
                end
                IDLE: begin
                    key_ready = 1'b1;
                    // A pending key outranks any job; no job is granted while it is offered.
                    if (key_valid) begin
                        state_nx = KEYEXP;
                    end else begin
                        gnt0       = req0_valid & (~req1_valid | ~rr_prio);
                        gnt1       = req1_valid & (~req0_valid | rr_prio);
                        req0_ready = gnt0;
                        req1_ready = gnt1;
                        if (gnt0 | gnt1) state_nx = RUN;
                    end
                end
                RUN: begin
                    if (cnt_zero) state_nx = DONE;
                end
                DONE: begin
                    // Handshake cycle returns to IDLE without granting.
                    if (rsp_ready) state_nx = IDLE;
                end
                default: state_nx = NOKEY;
            endcase
        end
        key_hs = key_ready & key_valid;
    end

    always_ff @(posedge HCLK) begin
        if (rst) begin
            state        <= NOKEY;
            cnt          <= '0;
            rr_prio      <= 1'b0;
            gnt_id       <= 1'b0;
            key_loaded   <= 1'b0;
            core_keyEna  <= 1'b0;
            core_keyword <= '0;
            core_encrypt <= 1'b0;
            core_data    <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_id       <= 1'b0;
        end else begin
            state       <= state_nx;
            core_keyEna <= key_hs;

            unique case (state)
                KEYEXP: begin
                    if (cnt_zero) key_loaded <= 1'b1;
                    else          cnt        <= cnt - 1'b1;
                end
                RUN: begin
                    if (cnt_zero) begin
                        rsp_data  <= core_result;
                        rsp_id    <= gnt_id;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase

            // Key and job handshakes only happen in NOKEY/IDLE, so they never
            // collide with the counter decrements above.
            if (key_hs) begin
                core_keyword <= key_in;
                cnt          <= KEY_CNT_INIT;
                key_loaded   <= 1'b0;
            end

            if (gnt0 | gnt1) begin
                core_data    <= gnt1 ? req1_data : req0_data;
                core_encrypt <= gnt1 ? req1_encrypt : req0_encrypt;
                gnt_id       <= gnt1;
                rr_prio      <= gnt0;
                cnt          <= CORE_CNT_INIT;
            end
        end
    end

endmodule

// File: tb/tb_aes_job_ctrl.sv
// tb_aes_job_ctrl
//   Randomised scoreboard bench for aes_job_ctrl. The AES core is replaced
//   by a stand-in whose cipher is a simple invertible mix. The stand-in also
//   answers the FIPS-197 known-answer pair exactly. It outputs a corrupted
//   value unless its inputs have been stable for CORE_LAT cycles under a
//   fully expanded key.
module tb_aes_job_ctrl;

    localparam int KEY_LAT  = 10;
    localparam int CORE_LAT = 11;

    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         HCLK;
    logic         rst          = 1'b1;
    logic         key_valid    = 1'b0;
    logic         key_ready;
    logic [127:0] key_in       = '0;
    logic         req0_valid   = 1'b0;
    logic         req1_valid   = 1'b0;
    logic         req0_ready;
    logic         req1_ready;
    logic         req0_encrypt = 1'b0;
    logic         req1_encrypt = 1'b0;
    logic [127:0] req0_data    = '0;
    logic [127:0] req1_data    = '0;
    logic         rsp_valid;
    logic         rsp_ready    = 1'b0;
    logic [127:0] rsp_data;
    logic         rsp_id;
    logic         key_loaded;
    logic         core_keyEna;
    logic [127:0] core_keyword;
    logic         core_encrypt;
    logic [127:0] core_data;
    logic [127:0] core_result  = '0;

    aes_job_ctrl #(.KEY_LAT(KEY_LAT), .CORE_LAT(CORE_LAT)) dut (
        .HCLK(HCLK), .rst(rst),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_encrypt(req0_encrypt), .req1_encrypt(req1_encrypt),
        .req0_data(req0_data), .req1_data(req1_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .key_loaded(key_loaded), .core_keyEna(core_keyEna),
        .core_keyword(core_keyword), .core_encrypt(core_encrypt),
        .core_data(core_data), .core_result(core_result)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Reference cipher shared by the core stand-in and the scoreboard.
    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic enc,
                                             input logic [127:0] d);
        logic [127:0] t;
        if (k == FIPS_K && enc && d == FIPS_P) return FIPS_C;
        if (k == FIPS_K && !enc && d == FIPS_C) return FIPS_P;
        if (enc) begin
            t = d ^ k;
            return {t[120:0], t[127:121]};
        end
        t = {d[6:0], d[127:7]};
        return t ^ k;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core stand-in
    logic [127:0] ck_word = '0;
    int           ck_age  = 0;
    int           cd_age  = 0;
    logic [127:0] cd_last = '0;
    logic         ce_last = 1'b0;
    logic [127:0] ck_last = '0;

    always @(negedge HCLK) begin
        if (core_keyEna) begin
            ck_age  = 0;
            ck_word = core_keyword;
        end else if (ck_age < 100000) begin
            ck_age++;
        end
        if (core_data !== cd_last || core_encrypt !== ce_last || core_keyword !== ck_last)
            cd_age = 1;
        else if (cd_age < 100000)
            cd_age++;
        cd_last = core_data;
        ce_last = core_encrypt;
        ck_last = core_keyword;
        if (cd_age >= CORE_LAT && ck_age >= KEY_LAT && ck_word == core_keyword)
            core_result = aes_ref(core_keyword, core_encrypt, core_data);
        else
            core_result = ~aes_ref(core_keyword, core_encrypt, core_data);
    end

    // Scoreboard entries and reference-model state
    typedef struct {
        logic         id;
        logic [127:0] data;
        bit           dir;
        logic [127:0] dir_data;
        logic         dir_id;
    } exp_t;

    exp_t         exp_q[$];
    int           cyc         = 0;
    int           m_key_cyc   = -1;
    int           m_grant_cyc = -1;
    logic [127:0] m_key       = '0;
    bit           m_last      = 1'b1;
    bit           busy        = 1'b0;
    bit           acc0 = 0, acc1 = 0, kacc = 0;
    bit           snap_rst = 1'b1;
    bit           kexp, idle;
    bit           e_kl, e_kena, e_kr, e_r0, e_r1, e_rv;

    // Directed known-answer expectation, armed by the stimulus thread.
    bit           dir_arm  = 1'b0;
    logic [127:0] dir_data = '0;
    logic         dir_id   = 1'b0;

    // Stimulus-side observer: derives per-cycle expectations from the rules,
    // then pushes an expected response whenever a job is accepted.
    always @(negedge HCLK) begin
        exp_t e;
        cyc++;
        acc0 = 1'b0;
        acc1 = 1'b0;
        kacc = 1'b0;
        if (rst) begin
            snap_rst    = 1'b1;
            exp_q.delete();
            m_key_cyc   = -1;
            m_grant_cyc = -1;
            m_last      = 1'b1;
            busy        = 1'b0;
        end else begin
            snap_rst = 1'b0;
            kexp   = (m_key_cyc >= 0) && (cyc > m_key_cyc) && (cyc <= m_key_cyc + KEY_LAT);
            e_kl   = (m_key_cyc >= 0) && (cyc > m_key_cyc + KEY_LAT);
            e_kena = (m_key_cyc >= 0) && (cyc == m_key_cyc + 1);
            e_kr   = !busy && !kexp;
            idle   = e_kl && !busy;
            e_r0   = idle && !key_valid && req0_valid && (!req1_valid || m_last);
            e_r1   = idle && !key_valid && req1_valid && (!req0_valid || !m_last);
            e_rv   = busy && (cyc > m_grant_cyc + CORE_LAT);

            kacc = key_valid & key_ready;
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;

            if (busy && rsp_valid && rsp_ready) busy = 1'b0;
            if (kacc) begin
                m_key     = key_in;
                m_key_cyc = cyc;
            end
            if (acc0 | acc1) begin
                e.id       = acc1;
                e.data     = acc1 ? aes_ref(m_key, req1_encrypt, req1_data)
                                  : aes_ref(m_key, req0_encrypt, req0_data);
                e.dir      = dir_arm;
                e.dir_data = dir_data;
                e.dir_id   = dir_id;
                exp_q.push_back(e);
                m_last      = acc1;
                m_grant_cyc = cyc;
                busy        = 1'b1;
            end
        end
    end

    // Monitor
    int           checks   = 0;
    int           failures = 0;
    int           npop     = 0;
    int           tmo_req  = 0;
    int           tmo_seen = 0;
    bit           end_req  = 1'b0;
    bit           end_done = 1'b0;
    bit           prev_rst  = 1'b1;
    bit           prev_hold = 1'b0;
    logic [127:0] prev_data = '0;
    logic         prev_id   = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always begin
        exp_t p;
        @(negedge HCLK);
        #2;
        if (tmo_req != tmo_seen) begin
            checks++;
            failures++;
            $display("FAIL timeout: waits expired %0d required 0 (cycle %0d)", tmo_req - tmo_seen, cyc);
            tmo_seen = tmo_req;
        end
        if (!snap_rst) begin
            if (prev_rst) begin
                chk("rst_ctrl", 128'({rsp_valid, key_loaded, core_keyEna, core_encrypt, rsp_id}), 128'(0));
                chk("rst_core_data", core_data, '0);
                chk("rst_keyword", core_keyword, '0);
                chk("rst_rsp_data", rsp_data, '0);
            end
            chk("key_ready", 128'(key_ready), 128'(e_kr));
            chk("key_loaded", 128'(key_loaded), 128'(e_kl));
            chk("core_keyEna", 128'(core_keyEna), 128'(e_kena));
            chk("req0_ready", 128'(req0_ready), 128'(e_r0));
            chk("req1_ready", 128'(req1_ready), 128'(e_r1));
            chk("rsp_valid", 128'(rsp_valid), 128'(e_rv));
            if (prev_hold) begin
                chk("hold_data", rsp_data, prev_data);
                chk("hold_id", 128'(rsp_id), 128'(prev_id));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got id %0d data %h required none (cycle %0d)",
                             rsp_id, rsp_data, cyc);
                end else begin
                    p = exp_q.pop_front();
                    npop++;
                    chk("rsp_data", rsp_data, p.data);
                    chk("rsp_id", 128'(rsp_id), 128'(p.id));
                    if (p.dir) begin
                        chk("kat_data", rsp_data, p.dir_data);
                        chk("kat_id", 128'(rsp_id), 128'(p.dir_id));
                    end
                end
            end
        end
        if (end_req && !end_done) begin
            chk("queue_empty", 128'(exp_q.size()), 128'(0));
            end_done = 1'b1;
        end
        prev_rst  = snap_rst;
        prev_hold = !snap_rst && rsp_valid && !rsp_ready;
        prev_data = rsp_data;
        prev_id   = rsp_id;
    end

    // Stimulus
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic hold_until(input int which);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            tick();
            n++;
            got = (which == 0) ? acc0 : ((which == 1) ? acc1 : kacc);
        end
        if (!got) tmo_req++;
    endtask

    task automatic wait_kl();
        int n;
        n = 0;
        while (!key_loaded && n < 200) begin
            tick();
            n++;
        end
        if (!key_loaded) tmo_req++;
    endtask

    task automatic wait_pop(input int target);
        int n;
        n = 0;
        while (npop < target && n < 400) begin
            tick();
            n++;
        end
        if (npop < target) tmo_req++;
    endtask

    initial begin
        int base;
        int grants;
        int n;

        // Reset for two cycles, then load the FIPS-197 key for one cycle.
        tick();
        tick();
        rst       = 1'b0;
        key_in    = FIPS_K;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        wait_kl();

        // Known-answer encrypt on requester 0.
        rsp_ready    = 1'b1;
        dir_arm      = 1'b1;
        dir_data     = FIPS_C;
        dir_id       = 1'b0;
        req0_encrypt = 1'b1;
        req0_data    = FIPS_P;
        req0_valid   = 1'b1;
        base         = npop;
        hold_until(0);
        req0_valid = 1'b0;
        dir_arm    = 1'b0;
        wait_pop(base + 1);

        // Known-answer decrypt on requester 1.
        dir_arm      = 1'b1;
        dir_data     = FIPS_P;
        dir_id       = 1'b1;
        req1_encrypt = 1'b0;
        req1_data    = FIPS_C;
        req1_valid   = 1'b1;
        base         = npop;
        hold_until(1);
        req1_valid = 1'b0;
        dir_arm    = 1'b0;
        wait_pop(base + 1);

        // Both requesters continuously valid for four jobs.
        base         = npop;
        grants       = 0;
        n            = 0;
        req0_data    = rand128();
        req1_data    = rand128();
        req0_encrypt = 1'($urandom);
        req1_encrypt = 1'($urandom);
        req0_valid   = 1'b1;
        req1_valid   = 1'b1;
        while (grants < 4 && n < 400) begin
            tick();
            n++;
            if (acc0) begin grants++; req0_data = rand128(); req0_encrypt = 1'($urandom); end
            if (acc1) begin grants++; req1_data = rand128(); req1_encrypt = 1'($urandom); end
        end
        if (grants < 4) tmo_req++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_pop(base + 4);

        // Backpressure, then key and job offered together in IDLE.
        rsp_ready  = 1'b0;
        req0_data  = rand128();
        req0_valid = 1'b1;
        hold_until(0);
        req0_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 100) begin tick(); n++; end
        if (!rsp_valid) tmo_req++;
        repeat (20) tick();
        rsp_ready = 1'b1;
        tick();
        base       = npop;
        key_in     = rand128();
        key_valid  = 1'b1;
        req0_data  = rand128();
        req0_valid = 1'b1;
        hold_until(2);
        key_valid = 1'b0;
        hold_until(0);
        req0_valid = 1'b0;
        wait_pop(base + 1);

        // Reset while a job is running; nothing may come out afterwards.
        req1_data  = rand128();
        req1_valid = 1'b1;
        hold_until(1);
        req1_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (40) tick();

        // Randomised traffic under a fresh key.
        key_in    = rand128();
        key_valid = 1'b1;
        hold_until(2);
        key_valid = 1'b0;
        wait_kl();
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (acc0) begin
                req0_valid = ($urandom % 3) != 0;
                req0_data = rand128(); req0_encrypt = 1'($urandom);
            end else if (!req0_valid) begin
                if ($urandom % 3 == 0) begin
                    req0_valid = 1'b1; req0_data = rand128(); req0_encrypt = 1'($urandom);
                end
            end else if ($urandom % 8 == 0) begin
                req0_data = rand128();
            end
            if (acc1) begin
                req1_valid = ($urandom % 3) != 0;
                req1_data = rand128(); req1_encrypt = 1'($urandom);
            end else if (!req1_valid) begin
                if ($urandom % 3 == 0) begin
                    req1_valid = 1'b1; req1_data = rand128(); req1_encrypt = 1'($urandom);
                end
            end else if ($urandom % 8 == 0) begin
                req1_encrypt = 1'($urandom);
            end
            if (kacc) key_valid = 1'b0;
            else if (!key_valid && $urandom % 300 == 0) begin
                key_valid = 1'b1; key_in = rand128();
            end
            rsp_ready = ($urandom % 4) != 0;
        end

        // Drain: let pending offers be accepted, then collect all responses.
        rsp_ready = 1'b1;
        n = 0;
        while ((req0_valid || req1_valid || key_valid) && n < 600) begin
            tick();
            n++;
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
            if (kacc) key_valid = 1'b0;
        end
        if (req0_valid || req1_valid || key_valid) tmo_req++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        key_valid  = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin tick(); n++; end
        repeat (3) tick();
        end_req = 1'b1;
        n = 0;
        while (!end_done && n < 10) begin tick(); n++; end
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
